// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared state type and helpers for the L2 slave round-robin arbiter
// Helpers operate on 32-bit vectors; callers zero-extend, so N_MASTER is limited to 32.
package l2_arb_pkg;

    typedef enum logic {ARB = 1'b0, STALL = 1'b1} arb_state_e;

    function automatic logic onehot_check(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // First set bit of req scanning cyclically from prio over n bits; prio when req is empty.
    // Scanning k downwards lets the lowest cyclic distance overwrite the result last.
    function automatic int rr_pick(input logic [31:0] req, input int prio, input int n);
        int j;
        rr_pick = prio;
        for (int k = 31; k >= 0; k--) begin
            j = (prio + k) % n;
            if (k < n && req[j]) rr_pick = j;
        end
    endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// l2_rr_pick: combinational cyclic priority encoder
// Ports: req (request vector), prio (scan start index) -> idx (winner index), valid (any request)
module l2_rr_pick
    import l2_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] prio,
    output logic [IW-1:0] idx,
    output logic          valid
);

    assign idx   = IW'(rr_pick(32'(req), int'(prio), N));
    assign valid = |req;

endmodule

// File: rtl/l2_slave_rr_arbiter.sv
// l2_slave_rr_arbiter: round-robin share of one L2 slave port between N_MASTER requesters
// Ports: clk/rst; per-master req_i/add_i/wen_i/wdata_i/be_i/aux_i in, gnt_o/r_valid_o out;
//        broadcast r_rdata_o/r_aux_o; slave request side slv_*_o with one-hot slv_ID_o and
//        slv_gnt_i; slave response side slv_r_valid_i/slv_r_rdata_i/slv_r_aux_i/slv_r_ID_i,
//        slv_r_gnt_o; sticky protocol error err_o.
module l2_slave_rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_MASTER        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int AUX_WIDTH       = 5,
    parameter int MAX_OUTSTANDING = 2
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] add_i,
    input  logic [N_MASTER-1:0]            wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   be_i,
    input  logic [N_MASTER*AUX_WIDTH-1:0]  aux_i,
    output logic [N_MASTER-1:0]            gnt_o,
    output logic [N_MASTER-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]          r_rdata_o,
    output logic [AUX_WIDTH-1:0]           r_aux_o,
    output logic                           slv_req_o,
    output logic [ADDR_WIDTH-1:0]          slv_add_o,
    output logic                           slv_wen_o,
    output logic [DATA_WIDTH-1:0]          slv_wdata_o,
    output logic [BE_WIDTH-1:0]            slv_be_o,
    output logic [AUX_WIDTH-1:0]           slv_aux_o,
    output logic [N_MASTER-1:0]            slv_ID_o,
    input  logic                           slv_gnt_i,
    input  logic                           slv_r_valid_i,
    output logic                           slv_r_gnt_o,
    input  logic [DATA_WIDTH-1:0]          slv_r_rdata_i,
    input  logic [AUX_WIDTH-1:0]           slv_r_aux_i,
    input  logic [N_MASTER-1:0]            slv_r_ID_i,
    output logic                           err_o
);

    localparam int IW = $clog2(N_MASTER);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e          state_q;
    logic [IW-1:0]       prio_q, lock_q, pick_idx, winner;
    logic [CW-1:0]       cnt_q;
    logic                err_q, pick_valid, can_issue, hs, ret, dec, id_ok, drop;
    logic [N_MASTER-1:0] win_oh;

    l2_rr_pick #(.N(N_MASTER)) u_pick (
        .req   (req_i),
        .prio  (prio_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A stalled transfer keeps its master regardless of newer requests.
    assign winner    = (state_q == STALL) ? lock_q : pick_idx;
    assign win_oh    = N_MASTER'(1) << winner;
    assign can_issue = cnt_q < CW'(MAX_OUTSTANDING);
    // Gating with rst keeps every output quiet while reset is held, even with live requests.
    assign slv_req_o = ~rst & can_issue & ((state_q == STALL) ? req_i[lock_q] : pick_valid);
    assign hs        = slv_req_o & slv_gnt_i;

    assign gnt_o       = hs ? win_oh : '0;
    assign slv_ID_o    = slv_req_o ? win_oh : '0;
    assign slv_add_o   = slv_req_o ? add_i[winner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign slv_wen_o   = slv_req_o & wen_i[winner];
    assign slv_wdata_o = slv_req_o ? wdata_i[winner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign slv_be_o    = slv_req_o ? be_i[winner*BE_WIDTH +: BE_WIDTH] : '0;
    assign slv_aux_o   = slv_req_o ? aux_i[winner*AUX_WIDTH +: AUX_WIDTH] : '0;

    assign ret   = slv_r_valid_i & ~rst;
    assign id_ok = onehot_check(32'(slv_r_ID_i));
    // A response with nothing outstanding is not counted so the counter cannot underflow.
    assign dec   = ret & (cnt_q != '0);
    assign drop  = (state_q == STALL) & ~req_i[lock_q];

    assign r_valid_o   = (ret & id_ok) ? slv_r_ID_i : '0;
    assign r_rdata_o   = rst ? '0 : slv_r_rdata_i;
    assign r_aux_o     = rst ? '0 : slv_r_aux_i;
    assign slv_r_gnt_o = ~rst;
    assign err_o       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            prio_q  <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (hs) begin
                state_q <= ARB;
                prio_q  <= (winner == IW'(N_MASTER - 1)) ? '0 : winner + IW'(1);
            end else if (slv_req_o) begin
                state_q <= STALL;
                lock_q  <= winner;
            end else if (drop) begin
                state_q <= ARB;
            end
            cnt_q <= cnt_q + CW'(hs) - CW'(dec);
            err_q <= err_q | (ret & ~(dec & id_ok)) | drop;
        end
    end

endmodule

// File: tb/tb_l2_slave_rr_arbiter.sv
// tb_l2_slave_rr_arbiter: directed and random checks of l2_slave_rr_arbiter against a behavioural model
module tb_l2_slave_rr_arbiter;

    localparam int N = 4, AW = 32, DW = 32, BW = 4, XW = 5, MAXO = 2;

    logic            clk = 1'b0, rst = 1'b0;
    logic [N-1:0]    req_i = '0, wen_i = '0, gnt_o, r_valid_o, slv_ID_o, slv_r_ID_i = '0;
    logic [N*AW-1:0] add_i = '0;
    logic [N*DW-1:0] wdata_i = '0;
    logic [N*BW-1:0] be_i = '0;
    logic [N*XW-1:0] aux_i = '0;
    logic [DW-1:0]   r_rdata_o, slv_wdata_o, slv_r_rdata_i = '0;
    logic [XW-1:0]   r_aux_o, slv_aux_o, slv_r_aux_i = '0;
    logic [AW-1:0]   slv_add_o;
    logic [BW-1:0]   slv_be_o;
    logic            slv_req_o, slv_wen_o, slv_gnt_i = 1'b0, slv_r_valid_i = 1'b0, slv_r_gnt_o, err_o;

    always #5 clk = ~clk;

    l2_slave_rr_arbiter #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .AUX_WIDTH(XW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
        .be_i(be_i), .aux_i(aux_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
        .r_aux_o(r_aux_o), .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
        .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o), .slv_aux_o(slv_aux_o), .slv_ID_o(slv_ID_o),
        .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_gnt_o(slv_r_gnt_o),
        .slv_r_rdata_i(slv_r_rdata_i), .slv_r_aux_i(slv_r_aux_i), .slv_r_ID_i(slv_r_ID_i),
        .err_o(err_o)
    );

    int n_chk = 0, n_pass = 0;
    int m_prio, m_lock, m_cnt;
    bit m_stall, m_err;
    logic [N-1:0]  o_gnt, o_id, o_rvalid;
    logic          o_req, o_err;
    logic [DW-1:0] o_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset;
        m_prio = 0; m_lock = 0; m_cnt = 0; m_stall = 0; m_err = 0;
    endtask

    // Drive one cycle of stimulus, compare every output with the model, then advance to posedge+1.
    task automatic step(input logic [N-1:0] req, input logic gnt, input logic rv,
                        input logic [N-1:0] rid, input logic [DW-1:0] rd);
        int win;
        bit sreq, hs, ok1h, bad;
        logic [N-1:0]  woh;
        logic [AW-1:0] e_add;
        logic [41:0]   e_pay;
        req_i = req; slv_gnt_i = gnt; slv_r_valid_i = rv; slv_r_ID_i = rid;
        slv_r_rdata_i = rd; slv_r_aux_i = XW'($urandom);
        for (int i = 0; i < N; i++) begin
            add_i[i*AW +: AW]   = $urandom;
            wdata_i[i*DW +: DW] = $urandom;
            be_i[i*BW +: BW]    = BW'($urandom);
            aux_i[i*XW +: XW]   = XW'($urandom);
        end
        wen_i = N'($urandom);
        #4;
        win = -1;
        if (m_stall) win = m_lock;
        else for (int k = 0; k < N; k++) if (win < 0 && req[(m_prio + k) % N]) win = (m_prio + k) % N;
        sreq = (win >= 0) ? (req[win] && m_cnt < MAXO) : 1'b0;
        hs = sreq && gnt;
        woh = '0; e_add = '0; e_pay = '0;
        if (sreq) begin
            woh   = N'(1) << win;
            e_add = add_i[win*AW +: AW];
            e_pay = {wen_i[win], be_i[win*BW +: BW], aux_i[win*XW +: XW], wdata_i[win*DW +: DW]};
        end
        ok1h = $countones(rid) == 1;
        chk("slv_req", slv_req_o, sreq);
        chk("slv_id", slv_ID_o, woh);
        chk("gnt", gnt_o, hs ? woh : '0);
        chk("slv_add", slv_add_o, e_add);
        chk("slv_payload", {slv_wen_o, slv_be_o, slv_aux_o, slv_wdata_o}, e_pay);
        chk("r_valid", r_valid_o, (rv && ok1h) ? rid : '0);
        chk("r_data", {r_aux_o, r_rdata_o}, {slv_r_aux_i, rd});
        chk("err", err_o, m_err);
        chk("cnt", dut.cnt_q, m_cnt);
        chk("r_gnt", slv_r_gnt_o, 1);
        o_gnt = gnt_o; o_id = slv_ID_o; o_rvalid = r_valid_o; o_req = slv_req_o;
        o_rdata = r_rdata_o; o_err = err_o;
        bad = (rv && (m_cnt == 0 || !ok1h)) || (m_stall && !req[m_lock]);
        if (hs) begin m_prio = (win + 1) % N; m_stall = 0; end
        else if (sreq) begin m_stall = 1; m_lock = win; end
        else if (m_stall && !req[m_lock]) m_stall = 0;
        if (rv && m_cnt > 0) m_cnt--;
        if (hs) m_cnt++;
        m_err |= bad;
        @(posedge clk); #1;
    endtask

    // Asynchronous reset with live requests and a live response: outputs must clear at once.
    task automatic do_reset;
        req_i = '1; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b1; slv_r_ID_i = 4'b0001;
        rst = 1'b1; #1;
        chk("rst_req", slv_req_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_id", slv_ID_o, 0);
        chk("rst_rvalid", r_valid_o, 0);
        chk("rst_add", slv_add_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rgnt", slv_r_gnt_o, 0);
        chk("rst_prio", dut.prio_q, 0);
        model_reset;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain;
        for (int g = 0; g < 8 && m_cnt > 0; g++) step('0, 1'b0, 1'b1, 4'b0001, $urandom);
        chk("drain", dut.cnt_q, 0);
    endtask

    initial begin
        logic [N-1:0] prev, req;
        int grants;
        #1;
        do_reset;

        prev = '0;
        for (int c = 0; c < 8; c++) begin
            step(4'hF, 1'b1, prev != '0, prev, $urandom);
            chk("A_order", o_gnt, 4'b0001 << (c % 4));
            prev = o_gnt;
        end
        step('0, 1'b0, 1'b1, prev, $urandom);

        step(4'b0100, 1'b0, 1'b0, '0, $urandom);
        chk("B_stall_id0", o_id, 4'b0100);
        step(4'b0101, 1'b0, 1'b0, '0, $urandom);
        chk("B_stall_id1", o_id, 4'b0100);
        step(4'b0101, 1'b0, 1'b0, '0, $urandom);
        chk("B_stall_id2", o_id, 4'b0100);
        step(4'b0101, 1'b1, 1'b0, '0, $urandom);
        chk("B_gnt2", o_gnt, 4'b0100);
        step(4'b0001, 1'b1, 1'b0, '0, $urandom);
        chk("B_gnt0", o_gnt, 4'b0001);
        drain;

        grants = 0;
        for (int c = 0; c < 4; c++) begin
            step(4'b0010, 1'b1, 1'b0, '0, $urandom);
            grants += int'(o_gnt[1]);
        end
        chk("C_grants", grants, 2);
        chk("C_block", o_req, 0);
        step(4'b0010, 1'b1, 1'b1, 4'b0010, $urandom);
        chk("C_same_cycle", o_req, 0);
        step(4'b0010, 1'b1, 1'b0, '0, $urandom);
        chk("C_reopen", o_gnt, 4'b0010);

        step('0, 1'b0, 1'b1, 4'b1000, 32'hDEADBEEF);
        chk("D_rvalid", o_rvalid, 4'b1000);
        chk("D_rdata", o_rdata, 32'hDEADBEEF);
        drain;

        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            if ($urandom_range(3) == 0) req = '0;
            if (m_stall) req[m_lock] = 1'b1;
            step(req, 1'($urandom_range(1)), m_cnt > 0 && $urandom_range(2) == 0,
                 (m_cnt > 0) ? N'(1) << $urandom_range(N - 1) : N'($urandom), $urandom);
        end
        chk("R_no_err", err_o, 0);
        drain;

        step('0, 1'b0, 1'b1, 4'b0001, $urandom);
        chk("E1_rvalid", o_rvalid, 4'b0001);
        chk("E1_err_late", o_err, 0);
        step('0, 1'b0, 1'b0, '0, $urandom);
        chk("E1_err", o_err, 1);
        step(4'b0001, 1'b1, 1'b0, '0, $urandom);
        chk("E1_sticky", err_o, 1);
        do_reset;

        step(4'b0001, 1'b1, 1'b0, '0, $urandom);
        step('0, 1'b0, 1'b1, 4'b0110, $urandom);
        chk("E2_rvalid", o_rvalid, 0);
        step('0, 1'b0, 1'b0, '0, $urandom);
        chk("E2_err", o_err, 1);
        do_reset;

        step(4'b0100, 1'b0, 1'b0, '0, $urandom);
        step('0, 1'b0, 1'b0, '0, $urandom);
        step('0, 1'b0, 1'b0, '0, $urandom);
        chk("E3_drop_err", o_err, 1);
        do_reset;

        step(4'b0010, 1'b1, 1'b0, '0, $urandom);
        step(4'b0100, 1'b0, 1'b0, '0, $urandom);
        chk("F_stall", dut.state_q, 1);
        chk("F_cnt", dut.cnt_q, 1);
        do_reset;
        step(4'hF, 1'b1, 1'b0, '0, $urandom);
        chk("F_first", o_gnt, 4'b0001);
        chk("F_err", o_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
